// File: rtl/serial_mem_pkg.sv
// Shared types and constants for the serial/video framebuffer memory bridge.
package serial_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_CMD,
    ST_V_WAIT,
    ST_S_WR,
    ST_S_WR_DONE,
    ST_S_RD,
    ST_S_RD_WAIT
  } state_t;

  localparam int          DEF_ADDR_W   = 24;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/serial_mem_bridge_if.sv
// Framebuffer memory port: valid/ready command channel plus a read-data strobe.
interface serial_mem_bridge_if #(
  parameter int ADDR_W = serial_mem_pkg::DEF_ADDR_W
);
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [15:0]       mem_wdata;
  logic              mem_rdata_valid;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    input  mem_cmd_ready, mem_rdata_valid, mem_rdata
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    output mem_cmd_ready, mem_rdata_valid, mem_rdata
  );
endinterface

// File: rtl/serial_mem_bridge_req_edge_latch.sv
// Rising-edge detector on a level request; holds one pending request and its payload.
module req_edge_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [W-1:0] i_payload,
  input  logic         i_clr,
  output logic         o_pend,
  output logic [W-1:0] o_payload
);

  logic         r_prev;
  logic         r_pend;
  logic [W-1:0] r_payload;
  logic         w_rise;

  assign w_rise = i_req & ~r_prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= 1'b0;
      r_pend    <= 1'b0;
      r_payload <= '0;
    end else begin
      r_prev <= i_req;
      if (i_clr) begin
        r_pend <= 1'b0;
      end else if (w_rise && !r_pend) begin
        // a second edge while pending is dropped: the first payload wins
        r_pend    <= 1'b1;
        r_payload <= i_payload;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_payload = r_payload;

endmodule

// File: rtl/serial_mem_bridge.sv
// Serial command / video scan-out arbiter onto one framebuffer memory port.
// Optional read watchdog enabled by defining SERIAL_BRIDGE_TIMEOUT_EN.
module serial_mem_bridge
  import serial_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_ram,
  input  logic                re_ram,
  input  logic [25:0]         addr,
  input  logic [7:0]          data0,
  input  logic [7:0]          data1,
  output logic                ack_wr,
  output logic                wr_valid,
  output logic                ack_re,
  output logic                re_valid,
  output logic [15:0]         rgb_in_o,
  input  logic                vid_rd_req,
  input  logic [ADDR_W-1:0]   vid_rd_addr,
  output logic                vid_rd_ack,
  output logic [15:0]         vid_rd_data,
  serial_mem_bridge_if.master mem,
  output logic                err_timeout
);

  state_t            r_state;
  logic              r_ack_wr, r_wr_valid, r_ack_re, r_re_valid, r_vid_rd_ack;
  logic [15:0]       r_rgb, r_vid_data;
  logic              r_cmd_valid, r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [15:0]       r_wdata;

  logic              w_wr_pend, w_rd_pend, w_wr_clr, w_rd_clr, w_timeout;
  logic [ADDR_W+15:0] w_wr_payload;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_unused_addr_hi;

  assign w_unused_addr_hi = ^addr[25:ADDR_W];
  assign w_wr_clr = (r_state == ST_S_WR) && mem.mem_cmd_ready;
  assign w_rd_clr = (r_state == ST_S_RD) && mem.mem_cmd_ready;

  req_edge_latch #(.W(ADDR_W + 16)) u_wr_latch (
    .clk(clk), .reset(reset), .i_req(wr_ram),
    .i_payload({addr[ADDR_W-1:0], data1, data0}),
    .i_clr(w_wr_clr), .o_pend(w_wr_pend), .o_payload(w_wr_payload)
  );

  req_edge_latch #(.W(ADDR_W)) u_rd_latch (
    .clk(clk), .reset(reset), .i_req(re_ram),
    .i_payload(addr[ADDR_W-1:0]),
    .i_clr(w_rd_clr), .o_pend(w_rd_pend), .o_payload(w_rd_addr)
  );

`ifdef SERIAL_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;
  logic            w_waiting;

  assign w_waiting = (r_state == ST_V_WAIT) || (r_state == ST_S_RD_WAIT);
  assign w_timeout = w_waiting && !mem.mem_rdata_valid &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_to_cnt <= w_waiting ? r_to_cnt + 1'b1 : '0;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ack_wr     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_ack_re     <= 1'b0;
      r_re_valid   <= 1'b0;
      r_vid_rd_ack <= 1'b0;
      r_rgb        <= '0;
      r_vid_data   <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_wdata      <= '0;
    end else begin
      r_ack_wr     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_ack_re     <= 1'b0;
      r_vid_rd_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // the requester still holds vid_rd_req during its ack cycle; do not reissue it
          if (vid_rd_req && !r_vid_rd_ack) begin
            r_state     <= ST_V_CMD;
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= vid_rd_addr;
          end else if (w_wr_pend) begin
            r_state     <= ST_S_WR;
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= 1'b1;
            r_cmd_addr  <= w_wr_payload[ADDR_W+15:16];
            r_wdata     <= w_wr_payload[15:0];
          end else if (w_rd_pend) begin
            r_state     <= ST_S_RD;
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= w_rd_addr;
            r_re_valid  <= 1'b0;
          end
        end
        ST_V_CMD: if (mem.mem_cmd_ready) begin
          r_cmd_valid <= 1'b0;
          r_state     <= ST_V_WAIT;
        end
        ST_S_WR: if (mem.mem_cmd_ready) begin
          r_cmd_valid <= 1'b0;
          r_ack_wr    <= 1'b1;
          r_state     <= ST_S_WR_DONE;
        end
        ST_S_WR_DONE: begin
          r_wr_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_S_RD: if (mem.mem_cmd_ready) begin
          r_cmd_valid <= 1'b0;
          r_state     <= ST_S_RD_WAIT;
        end
        ST_V_WAIT: if (mem.mem_rdata_valid || w_timeout) begin
          r_vid_data   <= mem.mem_rdata_valid ? mem.mem_rdata : TIMEOUT_DATA;
          r_vid_rd_ack <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_S_RD_WAIT: if (mem.mem_rdata_valid || w_timeout) begin
          r_rgb      <= mem.mem_rdata_valid ? mem.mem_rdata : TIMEOUT_DATA;
          r_ack_re   <= 1'b1;
          r_re_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack_wr            = r_ack_wr;
  assign wr_valid          = r_wr_valid;
  assign ack_re            = r_ack_re;
  assign re_valid          = r_re_valid;
  assign rgb_in_o          = r_rgb;
  assign vid_rd_ack        = r_vid_rd_ack;
  assign vid_rd_data       = r_vid_data;
  assign mem.mem_cmd_valid = r_cmd_valid;
  assign mem.mem_cmd_we    = r_cmd_we;
  assign mem.mem_cmd_addr  = r_cmd_addr;
  assign mem.mem_wdata     = r_wdata;

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge: serial write/read, video priority, stalls, edge handling.
module tb_serial_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_ram = 1'b0, re_ram = 1'b0;
  logic [25:0] addr = '0;
  logic [7:0]  data0 = '0, data1 = '0;
  logic        ack_wr, wr_valid, ack_re, re_valid, vid_rd_ack, err_timeout;
  logic [15:0] rgb_in_o, vid_rd_data;
  logic        vid_rd_req = 1'b0;
  logic [23:0] vid_rd_addr = '0;

  int checks = 0;
  int errors = 0;
  int n_accept = 0, n_ack_wr = 0, n_ack_re = 0, n_vid_ack = 0;

  serial_mem_bridge_if #(.ADDR_W(24)) mem_bus ();

  serial_mem_bridge #(.ADDR_W(24), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .wr_ram(wr_ram), .re_ram(re_ram), .addr(addr),
    .data0(data0), .data1(data1), .ack_wr(ack_wr), .wr_valid(wr_valid),
    .ack_re(ack_re), .re_valid(re_valid), .rgb_in_o(rgb_in_o),
    .vid_rd_req(vid_rd_req), .vid_rd_addr(vid_rd_addr), .vid_rd_ack(vid_rd_ack),
    .vid_rd_data(vid_rd_data), .mem(mem_bus), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_bus.mem_cmd_valid && mem_bus.mem_cmd_ready) n_accept++;
    if (ack_wr) n_ack_wr++;
    if (ack_re) n_ack_re++;
    if (vid_rd_ack) n_vid_ack++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_bus.mem_cmd_ready   = 1'b1;
    mem_bus.mem_rdata_valid = 1'b0;
    mem_bus.mem_rdata       = '0;
    reset = 1'b1;
    step(3);
    checks++;
    if ({ack_wr, wr_valid, ack_re, re_valid, vid_rd_ack, mem_bus.mem_cmd_valid, err_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {ack_wr, wr_valid, ack_re, re_valid, vid_rd_ack, mem_bus.mem_cmd_valid, err_timeout});
    end
    checks++;
    if ({rgb_in_o, vid_rd_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00000000", {rgb_in_o, vid_rd_data});
    end
    reset = 1'b0;
    step(2);
    checks++;
    if (mem_bus.mem_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b expected 0", mem_bus.mem_cmd_valid);
    end
  endtask

  task automatic test_write();
    int acc0;
    acc0 = n_accept;
    data1 = 8'h12; data0 = 8'h34; addr = 26'h000100; wr_ram = 1'b1;
    step();
    checks++;
    if (mem_bus.mem_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_latency_n1: got valid=%b expected 0", mem_bus.mem_cmd_valid);
    end
    step();
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, mem_bus.mem_wdata} !== {2'b11, 24'h000100, 16'h1234}) begin
      errors++;
      $display("FAIL wr_cmd: got v=%b we=%b a=%h d=%h expected v=1 we=1 a=000100 d=1234",
               mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, mem_bus.mem_wdata);
    end
    step();
    checks++;
    if ({ack_wr, wr_valid, mem_bus.mem_cmd_valid} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ack: got ack_wr/wr_valid/valid=%b expected 100", {ack_wr, wr_valid, mem_bus.mem_cmd_valid});
    end
    step();
    checks++;
    if ({ack_wr, wr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL wr_done: got ack_wr/wr_valid=%b expected 01", {ack_wr, wr_valid});
    end
    wr_ram = 1'b0;
    step(2);
    checks++;
    if (n_accept - acc0 !== 1) begin
      errors++;
      $display("FAIL wr_accepts: got %0d expected 1", n_accept - acc0);
    end
  endtask

  task automatic test_read();
    int early;
    int ar0;
    early = 0;
    addr = 26'h000200; re_ram = 1'b1;
    step(2);
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr} !== {2'b10, 24'h000200}) begin
      errors++;
      $display("FAIL rd_cmd: got v=%b we=%b a=%h expected v=1 we=0 a=000200",
               mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      if (ack_re) early++;
      step();
    end
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'hABCD;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    checks++;
    if ({early[0], ack_re, re_valid, rgb_in_o} !== {3'b011, 16'hABCD}) begin
      errors++;
      $display("FAIL rd_return: got early=%0d ack_re=%b re_valid=%b rgb=%h expected 0 1 1 abcd",
               early, ack_re, re_valid, rgb_in_o);
    end
    re_ram = 1'b0;
    step();
    ar0 = n_ack_re;
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'h5555;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    step(3);
    checks++;
    if ({ack_re, re_valid, rgb_in_o} !== {2'b01, 16'hABCD} || n_ack_re != ar0) begin
      errors++;
      $display("FAIL rd_hold_stray: got ack_re=%b re_valid=%b rgb=%h extra_acks=%0d expected 0 1 abcd 0",
               ack_re, re_valid, rgb_in_o, n_ack_re - ar0);
    end
  endtask

  task automatic test_video_priority();
    int acc0;
    acc0 = n_accept;
    vid_rd_req = 1'b1; vid_rd_addr = 24'h0A0B0C;
    wr_ram = 1'b1; addr = 26'h000300; data1 = 8'h56; data0 = 8'h78;
    step();
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr} !== {2'b10, 24'h0A0B0C}) begin
      errors++;
      $display("FAIL vid_first: got v=%b we=%b a=%h expected v=1 we=0 a=0a0b0c",
               mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr);
    end
    step();
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'h1111;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    checks++;
    if ({vid_rd_ack, vid_rd_data, ack_re} !== {1'b1, 16'h1111, 1'b0}) begin
      errors++;
      $display("FAIL vid_ack: got ack=%b data=%h ack_re=%b expected 1 1111 0", vid_rd_ack, vid_rd_data, ack_re);
    end
    step();
    vid_rd_req = 1'b0;
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, mem_bus.mem_wdata} !== {2'b11, 24'h000300, 16'h5678}) begin
      errors++;
      $display("FAIL wr_after_vid: got v=%b we=%b a=%h d=%h expected v=1 we=1 a=000300 d=5678",
               mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, mem_bus.mem_wdata);
    end
    wr_ram = 1'b0;
    step(5);
    checks++;
    if (n_accept - acc0 !== 2) begin
      errors++;
      $display("FAIL vid_wr_accepts: got %0d expected 2", n_accept - acc0);
    end
  endtask

  task automatic test_same_edge();
    wr_ram = 1'b1; re_ram = 1'b1; addr = 26'h000040; data1 = 8'h00; data0 = 8'h01;
    step(2);
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we} !== 2'b11) begin
      errors++;
      $display("FAIL same_edge_wr_first: got v=%b we=%b expected 1 1", mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we);
    end
    step(3);
    checks++;
    if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, re_valid} !== {2'b10, 24'h000040, 1'b0}) begin
      errors++;
      $display("FAIL same_edge_rd_next: got v=%b we=%b a=%h re_valid=%b expected 1 0 000040 0",
               mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, re_valid);
    end
    wr_ram = 1'b0; re_ram = 1'b0;
    step();
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'h0F0F;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    checks++;
    if ({ack_re, re_valid, rgb_in_o} !== {2'b11, 16'h0F0F}) begin
      errors++;
      $display("FAIL same_edge_rd_data: got ack_re=%b re_valid=%b rgb=%h expected 1 1 0f0f", ack_re, re_valid, rgb_in_o);
    end
    step(2);
  endtask

  task automatic test_ready_stall();
    int unstable;
    int acc0;
    unstable = 0;
    acc0 = n_accept;
    mem_bus.mem_cmd_ready = 1'b0;
    wr_ram = 1'b1; addr = 26'h2ABCDEF; data1 = 8'hAA; data0 = 8'h55;
    step(2);
    for (int i = 0; i < 10; i++) begin
      if ({mem_bus.mem_cmd_valid, mem_bus.mem_cmd_we, mem_bus.mem_cmd_addr, mem_bus.mem_wdata} !== {2'b11, 24'hABCDEF, 16'hAA55})
        unstable++;
      step();
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
    end
    mem_bus.mem_cmd_ready = 1'b1;
    step();
    wr_ram = 1'b0;
    checks++;
    if (ack_wr !== 1'b1) begin
      errors++;
      $display("FAIL stall_ack: got ack_wr=%b expected 1", ack_wr);
    end
    step(4);
    checks++;
    if (n_accept - acc0 !== 1) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 1", n_accept - acc0);
    end
  endtask

  task automatic test_drop_same_kind();
    int acc0;
    acc0 = n_accept;
    mem_bus.mem_cmd_ready = 1'b0;
    wr_ram = 1'b1; addr = 26'h000010; data1 = 8'hC0; data0 = 8'h01;
    step(2);
    wr_ram = 1'b0;
    step();
    wr_ram = 1'b1; addr = 26'h000020; data1 = 8'hC0; data0 = 8'h02;
    step(2);
    mem_bus.mem_cmd_ready = 1'b1;
    checks++;
    if ({mem_bus.mem_cmd_addr, mem_bus.mem_wdata} !== {24'h000010, 16'hC001}) begin
      errors++;
      $display("FAIL drop_first_wins: got a=%h d=%h expected a=000010 d=c001", mem_bus.mem_cmd_addr, mem_bus.mem_wdata);
    end
    step();
    wr_ram = 1'b0;
    step(10);
    checks++;
    if (n_accept - acc0 !== 1) begin
      errors++;
      $display("FAIL drop_accepts: got %0d expected 1", n_accept - acc0);
    end
  endtask

  task automatic test_held_wr();
    int acc0;
    int aw0;
    acc0 = n_accept;
    aw0  = n_ack_wr;
    wr_ram = 1'b1; addr = 26'h000050; data1 = 8'h0B; data0 = 8'hAD;
    step(100);
    wr_ram = 1'b0;
    step(3);
    checks++;
    if (n_accept - acc0 !== 1 || n_ack_wr - aw0 !== 1) begin
      errors++;
      $display("FAIL held_wr: got accepts=%0d ack_wr=%0d expected 1 1", n_accept - acc0, n_ack_wr - aw0);
    end
  endtask

  task automatic test_no_return();
    int cyc;
    addr = 26'h000060; re_ram = 1'b1;
    step(3);
    re_ram = 1'b0;
`ifdef SERIAL_BRIDGE_TIMEOUT_EN
    cyc = 0;
    while (!ack_re && cyc < 100) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 16 || {rgb_in_o, err_timeout, re_valid} !== {16'hDEAD, 2'b11}) begin
      errors++;
      $display("FAIL timeout: got cycles=%0d rgb=%h err=%b re_valid=%b expected 16 dead 1 1",
               cyc, rgb_in_o, err_timeout, re_valid);
    end
`else
    cyc = n_ack_re;
    step(40);
    checks++;
    if (n_ack_re != cyc || err_timeout !== 1'b0 || re_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got acks=%0d err=%b re_valid=%b expected 0 0 0", n_ack_re - cyc, err_timeout, re_valid);
    end
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'h7777;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    checks++;
    if ({ack_re, rgb_in_o} !== {1'b1, 16'h7777}) begin
      errors++;
      $display("FAIL late_return: got ack_re=%b rgb=%h expected 1 7777", ack_re, rgb_in_o);
    end
`endif
    step(2);
  endtask

  task automatic test_reset_mid();
    int ar0;
    addr = 26'h000070; re_ram = 1'b1;
    step(3);
    re_ram = 1'b0;
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ar0 = n_ack_re;
    mem_bus.mem_rdata_valid = 1'b1; mem_bus.mem_rdata = 16'h4242;
    step();
    mem_bus.mem_rdata_valid = 1'b0;
    step(2);
    checks++;
    if (n_ack_re != ar0 || {re_valid, rgb_in_o, mem_bus.mem_cmd_valid, err_timeout} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid: got acks=%0d re_valid=%b rgb=%h valid=%b err=%b expected 0 0 0000 0 0",
               n_ack_re - ar0, re_valid, rgb_in_o, mem_bus.mem_cmd_valid, err_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_video_priority();
    test_same_edge();
    test_ready_stall();
    test_drop_same_kind();
    test_held_wr();
    test_no_return();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
